// File: rtl/xaxi4_emb_pkg.sv
// ---------------------------------------------------------------------------
// xaxi4_emb_pkg
// Shared types and helpers for the embedded AXI4 slave interconnect blocks.
//   AXI_LEN_W      : width of AxLEN
//   RR_MAX_N       : largest requester count handled by rr_pick
//   rd_arb_state_e : read arbiter state encoding
//   rr_pick()      : one-hot round-robin pick, first requester at/after ptr
// ---------------------------------------------------------------------------
package xaxi4_emb_pkg;

  localparam int AXI_LEN_W = 8;
  localparam int RR_MAX_N  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_e;

  // Scans n requesters starting at ptr, wrapping modulo n. Bits at or above
  // n are ignored, so callers zero-extend narrower request vectors.
  function automatic logic [RR_MAX_N-1:0] rr_pick(
    input logic [RR_MAX_N-1:0] req,
    input logic [1:0]          ptr,
    input int unsigned         n
  );
    logic [RR_MAX_N-1:0] gnt;
    int unsigned         sum;
    logic [1:0]          idx;
    gnt = '0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      sum = (int'(ptr) + i) % n;
      idx = sum[1:0];
      if ((i < n) && (gnt == '0) && req[idx]) begin
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/xaxi4_emb_rr_arb.sv
// ---------------------------------------------------------------------------
// xaxi4_emb_rr_arb
// Round-robin picker with its own pointer register. The pick is purely
// combinational; the pointer moves to (granted index + 1) mod N only when
// the owner asserts advance, i.e. when it actually takes the grant.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset (pointer -> 0)
//   req           : per-requester request vector
//   advance       : commit the current pick and move the pointer past it
//   gnt           : one-hot pick (0 when no request)
//   gnt_idx       : binary index of the pick
// ---------------------------------------------------------------------------
module xaxi4_emb_rr_arb
  import xaxi4_emb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0]    ptr_q;
  logic [RR_MAX_N-1:0] req_ext;
  logic [1:0]          ptr_ext;
  logic [RR_MAX_N-1:0] pick;

  // NOTE: every signal written in an always_comb gets a default at the top
  // of the block so that no path leaves it unassigned (which would infer a
  // latch).
  always_comb begin
    req_ext            = '0;
    req_ext[N-1:0]     = req;
    ptr_ext            = '0;
    ptr_ext[IDX_W-1:0] = ptr_q;
    pick               = rr_pick(req_ext, ptr_ext, N);
    gnt                = pick[N-1:0];
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) gnt_idx = IDX_W'(i);
    end
  end

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/xaxi4_emb_rd_arb.sv
// ---------------------------------------------------------------------------
// xaxi4_emb_rd_arb
// Round-robin arbiter sharing the AR/R read port of the embedded AXI4 slave
// memory between NUM_M read masters. One burst is outstanding at a time:
// IDLE picks a master, ADDR forwards its AR, DATA routes R beats back to it
// until RLAST. Beats are counted and any RLAST/ARLEN disagreement raises a
// sticky o_len_err.
// Ports:
//   aclk, aresetn              : clock, asynchronous active-low reset
//   i_m_ar* / o_m_arready      : flattened per-master AR channels (slice k)
//   o_m_rvalid / i_m_rready    : per-master R handshake
//   o_m_rid/rresp/rdata/rlast  : R payload broadcast to all masters
//   o_s_ar* / i_s_arready      : AR channel to the slave
//   i_s_r* / o_s_rready        : R channel from the slave
//   o_gnt                      : one-hot current grant, 0 in IDLE
//   o_len_err / i_len_err_clr  : sticky length error and its clear
// Masters must hold their AR payload stable while ARVALID is high; the
// payload to the slave is a combinational mux of the granted slice.
// ---------------------------------------------------------------------------
module xaxi4_emb_rd_arb
  import xaxi4_emb_pkg::*;
#(
  parameter int NUM_M          = 2,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  // master side, AR
  input  logic [NUM_M-1:0]                  i_m_arvalid,
  output logic [NUM_M-1:0]                  o_m_arready,
  input  logic [NUM_M*AXI_ID_WIDTH-1:0]     i_m_arid,
  input  logic [NUM_M*AXI_ADDR_WIDTH-1:0]   i_m_araddr,
  input  logic [NUM_M*AXI_LEN_W-1:0]        i_m_arlen,
  input  logic [NUM_M*3-1:0]                i_m_arsize,
  input  logic [NUM_M*2-1:0]                i_m_arburst,
  // master side, R
  output logic [NUM_M-1:0]                  o_m_rvalid,
  input  logic [NUM_M-1:0]                  i_m_rready,
  output logic [AXI_ID_WIDTH-1:0]           o_m_rid,
  output logic [1:0]                        o_m_rresp,
  output logic [AXI_DATA_WIDTH-1:0]         o_m_rdata,
  output logic                              o_m_rlast,
  // slave side, AR
  output logic                              o_s_arvalid,
  input  logic                              i_s_arready,
  output logic [AXI_ID_WIDTH-1:0]           o_s_arid,
  output logic [AXI_ADDR_WIDTH-1:0]         o_s_araddr,
  output logic [AXI_LEN_W-1:0]              o_s_arlen,
  output logic [2:0]                        o_s_arsize,
  output logic [1:0]                        o_s_arburst,
  // slave side, R
  input  logic                              i_s_rvalid,
  output logic                              o_s_rready,
  input  logic [AXI_ID_WIDTH-1:0]           i_s_rid,
  input  logic [1:0]                        i_s_rresp,
  input  logic [AXI_DATA_WIDTH-1:0]         i_s_rdata,
  input  logic                              i_s_rlast,
  // status
  output logic [NUM_M-1:0]                  o_gnt,
  output logic                              o_len_err,
  input  logic                              i_len_err_clr
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  // Unpacked views of the flattened master AR payloads.
  logic [AXI_ID_WIDTH-1:0]   arid_a    [NUM_M];
  logic [AXI_ADDR_WIDTH-1:0] araddr_a  [NUM_M];
  logic [AXI_LEN_W-1:0]      arlen_a   [NUM_M];
  logic [2:0]                arsize_a  [NUM_M];
  logic [1:0]                arburst_a [NUM_M];

  for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
    assign arid_a[k]    = i_m_arid[k*AXI_ID_WIDTH +: AXI_ID_WIDTH];
    assign araddr_a[k]  = i_m_araddr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign arlen_a[k]   = i_m_arlen[k*AXI_LEN_W +: AXI_LEN_W];
    assign arsize_a[k]  = i_m_arsize[k*3 +: 3];
    assign arburst_a[k] = i_m_arburst[k*2 +: 2];
  end

  rd_arb_state_e        state_q, state_d;
  logic [NUM_M-1:0]     gnt_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [AXI_LEN_W-1:0] len_q;
  logic [AXI_LEN_W-1:0] beat_cnt_q;
  logic                 len_err_q;

  logic [NUM_M-1:0]     pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 take_grant;
  logic                 ar_hs;
  logic                 r_hs;
  logic                 len_err_set;

  // A grant is taken only from IDLE; requests seen in ADDR/DATA wait.
  assign take_grant = (state_q == IDLE) && (|i_m_arvalid);

  xaxi4_emb_rr_arb #(
    .N     (NUM_M),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (i_m_arvalid),
    .advance (take_grant),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // R payload is a straight pass-through; only the handshake is steered.
  assign o_m_rid   = i_s_rid;
  assign o_m_rresp = i_s_rresp;
  assign o_m_rdata = i_s_rdata;
  assign o_m_rlast = i_s_rlast;

  assign o_s_arid    = arid_a[gidx_q];
  assign o_s_araddr  = araddr_a[gidx_q];
  assign o_s_arlen   = arlen_a[gidx_q];
  assign o_s_arsize  = arsize_a[gidx_q];
  assign o_s_arburst = arburst_a[gidx_q];

  assign o_gnt     = gnt_q;
  assign o_len_err = len_err_q;

  always_comb begin
    state_d     = state_q;
    o_s_arvalid = 1'b0;
    o_m_arready = '0;
    o_m_rvalid  = '0;
    o_s_rready  = 1'b0;
    ar_hs       = 1'b0;
    r_hs        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|i_m_arvalid) state_d = ADDR;
      end
      ADDR: begin
        o_s_arvalid         = 1'b1;
        o_m_arready[gidx_q] = i_s_arready;
        ar_hs               = i_s_arready;
        if (i_s_arready) state_d = DATA;
      end
      DATA: begin
        o_m_rvalid[gidx_q] = i_s_rvalid;
        o_s_rready         = i_m_rready[gidx_q];
        r_hs               = i_s_rvalid & i_m_rready[gidx_q];
        if (r_hs && i_s_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // beat_cnt_q holds the number of beats already accepted, so on the beat
  // that should be last it equals len_q. RLAST anywhere else is an error, as
  // is a beat without RLAST at that position (the burst ran long).
  assign len_err_set = r_hs && ( i_s_rlast && (beat_cnt_q != len_q) ||
                                !i_s_rlast && (beat_cnt_q == len_q));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gidx_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (take_grant) begin
        gnt_q  <= pick_gnt;
        gidx_q <= pick_idx;
        len_q  <= arlen_a[pick_idx];
      end else if (r_hs && i_s_rlast) begin
        gnt_q <= '0;
      end

      if (ar_hs) begin
        beat_cnt_q <= '0;
      end else if (r_hs) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end

      // Clear wins over a same-cycle set; that error is deliberately lost.
      if (i_len_err_clr) begin
        len_err_q <= 1'b0;
      end else if (len_err_set) begin
        len_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/xaxi4_emb_rd_arb.md
Name: xaxi4_emb_rd_arb

Overview:
- Round-robin arbiter that lets NUM_M AXI4 read masters share the single read port (AR/R) of the embedded AXI4 slave memory.
- At most one read burst is outstanding at a time. The AR of the granted master is forwarded to the slave, and R beats are routed back to that master until the beat carrying RLAST.
- Also counts beats per burst and flags any mismatch between ARLEN and RLAST.
- Sits between the read masters and the embedded slave's i_ar*/o_r* ports; the write channels bypass it.

Parameters:
- NUM_M, 2, number of read masters (2..4)
- AXI_ID_WIDTH, 4, ID width, same on master and slave side
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- i_m_arvalid  input  NUM_M  per-master ARVALID
- o_m_arready  output  NUM_M  per-master ARREADY
- i_m_arid  input  NUM_M*AXI_ID_WIDTH  flattened ARID, master k at slice k
- i_m_araddr  input  NUM_M*AXI_ADDR_WIDTH  flattened ARADDR
- i_m_arlen  input  NUM_M*8  flattened ARLEN
- i_m_arsize  input  NUM_M*3  flattened ARSIZE
- i_m_arburst  input  NUM_M*2  flattened ARBURST
- o_m_rvalid  output  NUM_M  per-master RVALID
- i_m_rready  input  NUM_M  per-master RREADY
- o_m_rid  output  AXI_ID_WIDTH  RID, broadcast to all masters
- o_m_rresp  output  2  RRESP, broadcast
- o_m_rdata  output  AXI_DATA_WIDTH  RDATA, broadcast
- o_m_rlast  output  1  RLAST, broadcast
- o_s_arvalid  output  1  to slave i_arvalid
- i_s_arready  input  1  from slave o_arready
- o_s_arid / o_s_araddr / o_s_arlen / o_s_arsize / o_s_arburst  output  ID/ADDR/8/3/2  AR payload to slave
- i_s_rvalid  input  1  from slave o_rvalid
- o_s_rready  output  1  to slave i_rready
- i_s_rid / i_s_rresp / i_s_rdata / i_s_rlast  input  ID/2/DATA/1  R payload from slave
- o_gnt  output  NUM_M  one-hot current grant; 0 in IDLE
- o_len_err  output  1  sticky flag: RLAST position did not match ARLEN
- i_len_err_clr  input  1  synchronous clear of o_len_err

Behaviour:
- Reset (asynchronous, aresetn=0):
  - state=IDLE, round-robin pointer=0, o_gnt=0, beat counter=0, o_len_err=0.
  - All valid/ready outputs are 0.
  - The reset takes effect mid-burst with no completion; the slave must be reset together with this block.
- State IDLE:
  - If any i_m_arvalid is set, pick the first requester at or after the pointer (wrapping modulo NUM_M).
  - Register o_gnt, latch the granted ARLEN into len_q, set the pointer to grant index+1 (mod NUM_M), and go to ADDR.
  - No request: stay in IDLE.
- State ADDR:
  - o_s_arvalid=1; the AR payload is a combinational mux of the granted slice.
  - o_m_arready[g] = i_s_arready; all other o_m_arready bits are 0.
  - On i_s_arready: clear the beat counter and go to DATA.
  - Requests from other masters are ignored until the grant returns to IDLE.
- State DATA:
  - o_m_rvalid[g] = i_s_rvalid; o_s_rready = i_m_rready[g]; the R payload is passed through combinationally.
  - Each handshake increments the beat counter (8 bits).
  - On a handshake with i_s_rlast=1:
    - If the count != len_q, set o_len_err.
    - Clear o_gnt and go to IDLE.
  - If the count reaches len_q without rlast and a further beat arrives, also set o_len_err.
- Outside DATA: o_s_rready=0 and o_m_rvalid=0; stray slave beats are stalled.
- Latency and throughput:
  - ARVALID to slave ARVALID: 1 cycle (registered grant).
  - One bubble cycle in IDLE between bursts.
  - Single-beat read occupancy = 3 cycles, plus slave latency.
- o_len_err:
  - i_len_err_clr has priority over a set in the same cycle; the error is lost.
  - The clear takes effect on the next edge.
- The arbiter never drops a master's ARVALID and never reorders; RID is passed through unchanged.
- Requirement on masters: a master holding ARVALID must keep its payload stable (AXI rule). The arbiter depends on this because the payload mux is combinational.

Decomposition:
- Shared package xaxi4_emb_pkg:
  - rd_arb_state_e enum {IDLE, ADDR, DATA}
  - function rr_pick(req, ptr) returning a one-hot grant
  - AXI_LEN_W=8 constant
- One natural sub-module: xaxi4_emb_rr_arb, a parameterised round-robin picker with a pointer register. It is reusable for a later write-side arbiter.

Test Plan:
- Single master, NUM_M=2: m0 issues AR addr=0x100, len=3; slave returns 4 beats with rlast on beat 4.
  - o_s_arvalid is raised 1 cycle after m0 ARVALID.
  - m0 receives 4 beats; o_m_rvalid[1] stays 0; o_gnt returns to 0; o_len_err=0.
- Simultaneous: m0 and m1 both request len=0 from reset.
  - Order of grants is m0 then m1.
  - The second o_s_arvalid appears exactly 1 idle cycle after m0's RLAST handshake.
- Fairness: m0 and m1 hold requests continuously for 6 bursts.
  - Grants strictly alternate m0, m1, m0, m1, m0, m1.
- Backpressure: during a len=7 burst, i_m_rready[g] is toggled 1-0-1.
  - o_s_rready mirrors it each cycle; data order is preserved; exactly 8 beats are delivered.
- Length error:
  - Slave asserts rlast on beat 2 of a len=3 burst: o_len_err=1 after the handshake and FSM returns to IDLE.
  - Then i_len_err_clr=1 for 1 cycle: o_len_err=0.
- Reset mid-burst: aresetn is pulsed low during beat 2 of a len=5 burst.
  - Immediately: o_gnt=0 and all valids/readies are 0.
  - After release: the next request is granted to m0 (pointer=0).
